wb_trace_buffer: RTL and testbench

//   Captures every register writeback committed by the pipeline's WB stage (regWrite, WA, WD) into a

---
 rtl/wb_trace_buffer.sv | 123 ++++++++++++
 tb/tb_wb_trace_buffer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: records every committed register writeback {WA, WD, ts}
// into a circular FIFO and drains it through a valid/ready port with
// first-word-fall-through outputs.
module wb_trace_buffer #(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 3,
    parameter int DEPTH        = 8,
    parameter int TS_W         = 16,
    parameter bit STOP_ON_FULL = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cap_en,
    input  logic                       wb_regWrite,
    input  logic [ADDR_W-1:0]          wb_WA,
    input  logic [DATA_W-1:0]          wb_WD,
    output logic                       trace_valid,
    input  logic                       trace_ready,
    output logic [ADDR_W-1:0]          trace_addr,
    output logic [DATA_W-1:0]          trace_data,
    output logic [TS_W-1:0]            trace_ts,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [7:0]                 drop_cnt,
    output logic                       halted
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [TS_W-1:0]   ts;
    } entry_t;

    state_t             state, next_state;
    entry_t             mem [DEPTH];
    entry_t             head, last_q;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [TS_W-1:0]    ts;
    logic               push_req, push, pop, full, drop;

    assign trace_valid = (count != '0);
    assign full        = (count == CNT_W'(DEPTH));
    assign pop         = trace_valid && trace_ready;
    assign push_req    = (state == RUN) && wb_regWrite;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push        = push_req && (!full || pop);
    assign drop        = push_req && full && !pop;
    assign halted      = (state == HALT);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state logic: cap_en arms/disarms; a drop halts capture when STOP_ON_FULL is set.
    always_comb begin
        // NOTE: default first so no path leaves next_state unassigned (no latch).
        next_state = state;
        unique case (state)
            IDLE: if (cap_en) next_state = RUN;
            RUN: begin
                if (drop && STOP_ON_FULL) next_state = HALT;
                else if (!cap_en)         next_state = IDLE;
            end
            HALT:    next_state = HALT;
            default: next_state = IDLE;
        endcase
    end

    // Entry storage; the stored ts is the value before this cycle's increment.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; trace_valid gates every read, so stale words are never seen.
        if (push) mem[wr_ptr] <= '{addr: wb_WA, data: wb_WD, ts: ts};
    end

    // Pointers, occupancy, timestamp and drop bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ts       <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (state == RUN) ts <= ts + 1'b1;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    // Shadow of the head so the outputs hold their last value once the FIFO empties.
    always_ff @(posedge clk) begin
        if (rst)              last_q <= '0;
        else if (trace_valid) last_q <= mem[rd_ptr];
    end

    assign head       = trace_valid ? mem[rd_ptr] : last_q;
    assign trace_addr = head.addr;
    assign trace_data = head.data;
    assign trace_ts   = head.ts;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Bench for wb_trace_buffer: two instances (STOP_ON_FULL=0 and 1) share the
// stimulus; a small reference model predicts accepted entries into a
// scoreboard queue which is popped and compared as the DUT drains.
module tb_wb_trace_buffer;

    typedef struct packed {
        logic [2:0]  a;
        logic [15:0] d;
        logic [15:0] t;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, cap_en, wr, ready;
    logic [2:0]  wa;
    logic [15:0] wd;

    logic        v0, v1, ov0, ov1, h0, h1;
    logic [2:0]  a0, a1;
    logic [15:0] d0, d1, t0, t1;
    logic [3:0]  c0, c1;
    logic [7:0]  dc0, dc1;

    // Observed instance select: 0 -> STOP_ON_FULL=0, 1 -> STOP_ON_FULL=1.
    logic        sel = 1'b0;
    logic        o_valid, o_ovf, o_halt;
    logic [2:0]  o_addr;
    logic [15:0] o_data, o_ts;
    logic [3:0]  o_count;
    logic [7:0]  o_drops;

    assign o_valid = sel ? v1  : v0;
    assign o_addr  = sel ? a1  : a0;
    assign o_data  = sel ? d1  : d0;
    assign o_ts    = sel ? t1  : t0;
    assign o_count = sel ? c1  : c0;
    assign o_ovf   = sel ? ov1 : ov0;
    assign o_drops = sel ? dc1 : dc0;
    assign o_halt  = sel ? h1  : h0;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    exp_t        sb[$];
    int          m_state;   // 0 idle, 1 run, 2 halt
    int          m_count;
    logic [15:0] m_ts;

    always #5 clk = ~clk;

    wb_trace_buffer #(.STOP_ON_FULL(1'b0)) dut0 (
        .clk(clk), .rst(rst), .cap_en(cap_en), .wb_regWrite(wr), .wb_WA(wa), .wb_WD(wd),
        .trace_valid(v0), .trace_ready(ready), .trace_addr(a0), .trace_data(d0), .trace_ts(t0),
        .count(c0), .overflow(ov0), .drop_cnt(dc0), .halted(h0));

    wb_trace_buffer #(.STOP_ON_FULL(1'b1)) dut1 (
        .clk(clk), .rst(rst), .cap_en(cap_en), .wb_regWrite(wr), .wb_WA(wa), .wb_WD(wd),
        .trace_valid(v1), .trace_ready(ready), .trace_addr(a1), .trace_data(d1), .trace_ts(t1),
        .count(c1), .overflow(ov1), .drop_cnt(dc1), .halted(h1));

    // Called at a negedge with inputs set: predict the coming posedge, compare
    // any popped head against the scoreboard, then advance to the next negedge.
    task automatic cycle();
        logic pop, push_req, full, drop;
        exp_t e;
        if (rst) begin
            m_state = 0;
            m_count = 0;
            m_ts    = '0;
            sb.delete();
        end else begin
            pop = (m_count != 0) && ready;
            if (pop && sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                if ({o_addr, o_data, o_ts} !== {e.a, e.d, e.t}) begin
                    errors++;
                    $display("FAIL pop_entry: got addr=%0d data=%h ts=%0d, expected addr=%0d data=%h ts=%0d",
                             o_addr, o_data, o_ts, e.a, e.d, e.t);
                end
            end
            push_req = (m_state == 1) && wr;
            full     = (m_count == 8);
            drop     = push_req && full && !pop;
            if (push_req && !drop) sb.push_back('{a: wa, d: wd, t: m_ts});
            m_count = m_count + ((push_req && !drop) ? 1 : 0) - (pop ? 1 : 0);
            if (m_state == 1) begin
                m_ts = m_ts + 16'd1;
                if (drop && sel)  m_state = 2;
                else if (!cap_en) m_state = 0;
            end else if (m_state == 0 && cap_en) begin
                m_state = 1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (o_count !== 4'(m_count) || o_valid !== (m_count != 0)) begin
            errors++;
            $display("FAIL occupancy: got count=%0d valid=%b, expected count=%0d valid=%b",
                     o_count, o_valid, m_count, (m_count != 0));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic wb(input logic [2:0] a, input logic [15:0] d);
        wr = 1'b1; wa = a; wd = d;
        cycle();
        wr = 1'b0;
    endtask

    task automatic drain();
        ready = 1'b1;
        for (int i = 0; i < 40 && m_count != 0; i++) cycle();
        ready = 1'b0;
    endtask

    task automatic test_reset();
        sel = 1'b0;
        do_reset();
        checks++;
        if ({o_valid, o_addr, o_data, o_ts, o_ovf, o_drops, o_halt} !== '0) begin
            errors++;
            $display("FAIL reset_state: got valid=%b addr=%0d data=%h ts=%h ovf=%b drops=%0d halted=%b, expected all 0",
                     o_valid, o_addr, o_data, o_ts, o_ovf, o_drops, o_halt);
        end
    endtask

    task automatic test_basic();
        cap_en = 1'b1;
        cycle();
        wb(3'd1, 16'h0005);
        checks++;
        if (o_valid !== 1'b1 || o_data !== 16'h0005 || o_ts !== 16'd0) begin
            errors++;
            $display("FAIL first_latency: got valid=%b data=%h ts=%0d, expected valid=1 data=0005 ts=0",
                     o_valid, o_data, o_ts);
        end
        wb(3'd2, 16'h000A);
        wb(3'd3, 16'hFFFF);
        checks++;
        if (o_count !== 4'd3) begin
            errors++;
            $display("FAIL basic_peak: got count=%0d, expected 3", o_count);
        end
        drain();
        checks++;
        if (o_ovf !== 1'b0 || o_valid !== 1'b0 || o_data !== 16'hFFFF || o_ts !== 16'd2) begin
            errors++;
            $display("FAIL basic_after_drain: got ovf=%b valid=%b data=%h ts=%0d, expected ovf=0 valid=0 data=ffff ts=2",
                     o_ovf, o_valid, o_data, o_ts);
        end
    endtask

    task automatic test_overflow();
        ready = 1'b0;
        for (int i = 0; i < 10; i++) wb(3'(i), 16'h0100 + 16'(i));
        checks++;
        if (o_count !== 4'd8 || o_ovf !== 1'b1 || o_drops !== 8'd2 || o_halt !== 1'b0) begin
            errors++;
            $display("FAIL overflow: got count=%0d ovf=%b drops=%0d halted=%b, expected 8 1 2 0",
                     o_count, o_ovf, o_drops, o_halt);
        end
    endtask

    task automatic test_full_push_pop();
        ready = 1'b1;
        wb(3'd7, 16'hBEEF);
        ready = 1'b0;
        checks++;
        if (o_count !== 4'd8 || o_drops !== 8'd2) begin
            errors++;
            $display("FAIL full_push_pop: got count=%0d drops=%0d, expected 8 2", o_count, o_drops);
        end
        drain();
    endtask

    task automatic test_stop_on_full();
        sel = 1'b1;
        do_reset();
        cap_en = 1'b1;
        cycle();
        for (int i = 0; i < 9; i++) wb(3'(i), 16'h0200 + 16'(i));
        checks++;
        if (o_halt !== 1'b1 || o_ovf !== 1'b1 || o_drops !== 8'd1 || o_count !== 4'd8) begin
            errors++;
            $display("FAIL stop_halt: got halted=%b ovf=%b drops=%0d count=%0d, expected 1 1 1 8",
                     o_halt, o_ovf, o_drops, o_count);
        end
        for (int i = 0; i < 3; i++) wb(3'd5, 16'h0DEAD);
        checks++;
        if (o_count !== 4'd8 || o_drops !== 8'd1) begin
            errors++;
            $display("FAIL stop_ignore: got count=%0d drops=%0d, expected 8 1", o_count, o_drops);
        end
        drain();
        checks++;
        if (o_valid !== 1'b0 || o_halt !== 1'b1) begin
            errors++;
            $display("FAIL stop_drained: got valid=%b halted=%b, expected 0 1", o_valid, o_halt);
        end
        do_reset();
        checks++;
        if (o_halt !== 1'b0) begin
            errors++;
            $display("FAIL stop_reset: got halted=%b, expected 0", o_halt);
        end
        sel = 1'b0;
    endtask

    task automatic test_cap_gap();
        sel = 1'b0;
        cap_en = 1'b0;
        do_reset();
        cap_en = 1'b1;
        cycle();
        wb(3'd1, 16'h1111);
        cap_en = 1'b0;
        cycle();
        for (int i = 0; i < 4; i++) wb(3'd6, 16'h6666);
        checks++;
        if (o_count !== 4'd1) begin
            errors++;
            $display("FAIL gap_ignored: got count=%0d, expected 1", o_count);
        end
        cap_en = 1'b1;
        cycle();
        wb(3'd0, 16'h2222);
        wb(3'd2, 16'h3333);
        wb(3'd3, 16'h4444);
        checks++;
        if (o_count !== 4'd4 || o_ts !== 16'd0) begin
            errors++;
            $display("FAIL gap_held: got count=%0d head_ts=%0d, expected 4 0", o_count, o_ts);
        end
        ready = 1'b1;
        cycle();
        cycle();
        checks++;
        if (o_ts !== 16'd3 || o_data !== 16'h3333) begin
            errors++;
            $display("FAIL gap_ts_frozen: got ts=%0d data=%h, expected 3 3333", o_ts, o_data);
        end
        ready = 1'b0;
        do_reset();
        checks++;
        if (o_valid !== 1'b0 || o_count !== 4'd0) begin
            errors++;
            $display("FAIL reset_discard: got valid=%b count=%0d, expected 0 0", o_valid, o_count);
        end
    endtask

    initial begin
        rst = 1'b1; cap_en = 1'b0; wr = 1'b0; ready = 1'b0; wa = '0; wd = '0;
        m_state = 0; m_count = 0; m_ts = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_overflow();
        test_full_push_pop();
        test_stop_on_full();
        test_cap_gap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
